// File: rtl/irq_entry_ctrl_pkg.sv
// Shared types and constants for the SimpleRISC interrupt entry/return sequencer.
// Holds the FSM state encoding and the default vector/EPC settings.
package irq_entry_ctrl_pkg;

    localparam int          FLAGS_W          = 2;
    localparam int          SYNC_STAGES_DEF  = 2;
    localparam logic [31:0] VECTOR_ADDR_DEF  = 32'h0000_0100;
    localparam logic [3:0]  EPC_REG_DEF      = 4'd12;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SAVE   = 3'd1,
        ST_VECTOR = 3'd2,
        ST_ISR    = 3'd3,
        ST_RETURN = 3'd4
    } irq_state_e;

    // States in which the core must hold its PC and drop its own writeback.
    function automatic logic state_stalls(input irq_state_e st);
        logic res;
        case (st)
            ST_SAVE:   res = 1'b1;
            ST_VECTOR: res = 1'b1;
            ST_RETURN: res = 1'b1;
            default:   res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/irq_entry_ctrl_sync.sv
// Multi-stage synchroniser for the asynchronous interrupt pin with a
// rising-edge detector behind it.
module irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   hist_r;

    // Synchroniser chain plus one history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= '0;
            hist_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], async_in};
            hist_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign rise = sync_r[SYNC_STAGES-1] & ~hist_r;

endmodule

// File: rtl/irq_entry_ctrl.sv
// Interrupt entry/return sequencer: latches a synchronised request, saves the
// return PC into EPC at an instruction boundary, vectors, and restores on reti.
module irq_entry_ctrl
    import irq_entry_ctrl_pkg::*;
#(
    parameter logic [31:0] VECTOR_ADDR = VECTOR_ADDR_DEF,
    parameter logic [3:0]  EPC_REG     = EPC_REG_DEF,
    parameter int          SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               irq_req,
    input  logic               irq_enable,
    input  logic               instr_done,
    input  logic               is_reti,
    input  logic [31:0]        pc_next,
    input  logic [FLAGS_W-1:0] flags_in,
    output logic               stall,
    output logic               wb_we,
    output logic [3:0]         wb_addr,
    output logic [31:0]        wb_data,
    output logic               pc_redirect,
    output logic [31:0]        pc_target,
    output logic               flags_restore,
    output logic [FLAGS_W-1:0] flags_val,
    output logic               in_isr,
    output logic               spurious_reti
);

    irq_state_e         state_r;
    irq_state_e         state_s;
    logic               pending_r;
    logic [31:0]        epc_r;
    logic [FLAGS_W-1:0] shadow_flags_r;
    logic               spurious_r;
    logic               irq_rise_s;
    logic               enter_save_s;

    irq_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (irq_req),
        .rise     (irq_rise_s)
    );

    // irq_enable only matters here, so clearing it inside the ISR is harmless.
    assign enter_save_s = (state_r == ST_IDLE) & pending_r & irq_enable & instr_done;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enter_save_s) begin
                    state_s = ST_SAVE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SAVE: begin
                state_s = ST_VECTOR;
            end
            ST_VECTOR: begin
                state_s = ST_ISR;
            end
            ST_ISR: begin
                if (instr_done && is_reti) begin
                    state_s = ST_RETURN;
                end else begin
                    state_s = ST_ISR;
                end
            end
            ST_RETURN: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Pending latch, saved context and spurious-reti flag.
    // A new edge coinciding with the entry clear keeps the request alive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r      <= 1'b0;
            epc_r          <= 32'h0000_0000;
            shadow_flags_r <= '0;
            spurious_r     <= 1'b0;
        end else begin
            pending_r  <= irq_rise_s | (pending_r & ~enter_save_s);
            spurious_r <= (state_r == ST_IDLE) & instr_done & is_reti;
            if (state_r == ST_SAVE) begin
                epc_r          <= pc_next;
                shadow_flags_r <= flags_in;
            end else begin
                epc_r          <= epc_r;
                shadow_flags_r <= shadow_flags_r;
            end
        end
    end

    // Output decode of the registered state; data buses stay 0 unless strobed.
    always_comb begin
        stall         = state_stalls(state_r);
        wb_we         = 1'b0;
        wb_addr       = 4'd0;
        wb_data       = 32'h0000_0000;
        pc_redirect   = 1'b0;
        pc_target     = 32'h0000_0000;
        flags_restore = 1'b0;
        flags_val     = '0;
        in_isr        = 1'b0;
        case (state_r)
            ST_SAVE: begin
                wb_we   = 1'b1;
                wb_addr = EPC_REG;
                wb_data = pc_next;
            end
            ST_VECTOR: begin
                pc_redirect = 1'b1;
                pc_target   = VECTOR_ADDR;
            end
            ST_ISR: begin
                in_isr = 1'b1;
            end
            ST_RETURN: begin
                pc_redirect   = 1'b1;
                pc_target     = epc_r;
                flags_restore = 1'b1;
                flags_val     = shadow_flags_r;
            end
            default: begin
                in_isr = 1'b0;
            end
        endcase
    end

    assign spurious_reti = spurious_r;

endmodule

// File: doc/irq_entry_ctrl.md
Name: irq_entry_ctrl

Overview:
- Interrupt entry/return sequencer for the SimpleRISC single-cycle core.
- Sits between the external interrupt pin and the register file / PC logic.
- Synchronises and latches the request, then waits for an instruction boundary.
- Stalls the core for two cycles to write the return PC into the EPC register through the register-file write port and redirect fetch to the vector; on reti it restores PC and flags.

Parameters:
- VECTOR_ADDR, 32'h0000_0100, ISR entry address.
- EPC_REG, 4'd12, register-file index that receives the return PC.
- SYNC_STAGES, 2, synchroniser depth for irq_req (minimum 2).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- irq_req  in  1  asynchronous interrupt request; only rising edges count.
- irq_enable  in  1  global interrupt enable.
- instr_done  in  1  current instruction retires this cycle.
- is_reti  in  1  retiring instruction is reti; qualified by instr_done.
- pc_next  in  32  PC the core would fetch next.
- flags_in  in  2  current {gt, eq} flags.
- stall  out  1  freeze core PC and suppress core writeback.
- wb_we  out  1  register-file write enable, priority over core writeback.
- wb_addr  out  4  register-file write index.
- wb_data  out  32  register-file write data.
- pc_redirect  out  1  load pc_target into PC this cycle.
- pc_target  out  32  redirect address.
- flags_restore  out  1  load flags_val into the flags register.
- flags_val  out  2  restored flags.
- in_isr  out  1  ISR active.
- spurious_reti  out  1  one-cycle pulse when reti retires outside an ISR.

Behaviour:
- Reset:
  - state IDLE; pending, sync flops, epc, shadow_flags cleared.
  - All outputs 0.
  - Reset mid-sequence aborts immediately; no partial write completes after rst_n falls.
- Synchroniser:
  - SYNC_STAGES flops plus one edge-history flop.
  - Edge = sync_out & ~hist.
  - Edge sets sticky pending on the next clk.
  - Pin rise to pending high: SYNC_STAGES+1 clocks.
- Pending:
  - Cleared on entering SAVE.
  - An edge in the same cycle as the clear wins; pending stays 1.
  - Edges during SAVE, VECTOR or ISR are held and served after return.
  - Edges while already pending merge; no counting.
- FSM:
  - IDLE: if pending & irq_enable & instr_done -> SAVE. Otherwise stay.
  - IDLE: if instr_done & is_reti, pulse spurious_reti and stay.
  - SAVE (1 cycle):
    - stall=1, wb_we=1, wb_addr=EPC_REG, wb_data=pc_next.
    - epc<=pc_next; shadow_flags<=flags_in; pending cleared.
    - -> VECTOR.
  - VECTOR (1 cycle): stall=1, pc_redirect=1, pc_target=VECTOR_ADDR -> ISR.
  - ISR:
    - in_isr=1; no nesting.
    - On instr_done & is_reti -> RETURN.
  - RETURN (1 cycle):
    - stall=1, pc_redirect=1, pc_target=epc.
    - flags_restore=1, flags_val=shadow_flags.
    - -> IDLE.
  - A pending request may enter SAVE on the first instr_done after RETURN.
- Entry latency: instr_done cycle + 2 stall cycles. The first ISR fetch is on the third cycle.
- irq_enable is sampled only in IDLE; deasserting it in ISR has no effect.
- All outputs are registered-state decodes. wb_data and pc_target are 0 when the corresponding strobe is low.

Decomposition:
- Shared package: FSM state encoding (IDLE, SAVE, VECTOR, ISR, RETURN), VECTOR_ADDR default, EPC_REG index, flags width.
- One sub-module: irq_sync (parameterised SYNC_STAGES synchroniser plus rising-edge detect, async active-low reset).

Test Plan:
- Reset, then pulse irq_req with irq_enable=1, instr_done=1, pc_next=32'h40:
  - pending rises SYNC_STAGES+1 clocks after the pin.
  - Next cycle: wb_we=1, wb_addr=12, wb_data=32'h40.
  - Following cycle: pc_redirect=1, pc_target=32'h100, then in_isr=1.
- In ISR with flags saved as 2'b10, retire reti -> pc_redirect=1, pc_target=32'h40, flags_restore=1, flags_val=2'b10; in_isr=0 next cycle.
- Second irq edge during ISR -> no re-entry. After RETURN, the next instr_done enters SAVE with wb_data equal to the pc_next at that time.
- irq_enable=0 with pending=1 for 10 instructions -> no stall. Raise irq_enable -> SAVE on the next instr_done.
- reti retired in IDLE -> spurious_reti=1 for exactly one cycle; no redirect.
- Assert rst_n=0 during VECTOR -> all outputs 0 asynchronously, state IDLE, pending 0.
